// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: mode encodings, round counts, sequencer FSM
// state type and the 80-entry SHA-512 round-constant table. The SHA-256
// constants are the upper 32 bits of the first 64 entries, so one table
// serves both hash families.
package sha2_pkg;

    typedef enum logic {
        SHA2_MODE_256 = 1'b0,
        SHA2_MODE_512 = 1'b1
    } sha2_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sha2_seq_state_e;

    localparam int unsigned SHA256_ROUNDS   = 64;
    localparam int unsigned SHA512_ROUNDS   = 80;
    localparam int unsigned SHA256_LAST_RND = 63;
    localparam int unsigned SHA512_LAST_RND = 79;

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic int unsigned sha2_last_round(sha2_mode_e m);
        return (m == SHA2_MODE_512) ? SHA512_LAST_RND : SHA256_LAST_RND;
    endfunction

endpackage

// File: rtl/sha2_k_sequencer_if.sv
// Stream/control bundle between the block controller, the round-constant
// sequencer and the compression datapath.
//   master : drives start, mode, abort (controller) and k_ready (consumer)
//   slave  : the sequencer; drives k_valid/k_data/k_round/k_last, busy, done
interface sha2_k_sequencer_if #(
    parameter int unsigned OUT_W = 64,
    parameter int unsigned RND_W = 7
);
    logic             start;
    logic             mode;
    logic             abort;
    logic             k_ready;
    logic             k_valid;
    logic [OUT_W-1:0] k_data;
    logic [RND_W-1:0] k_round;
    logic             k_last;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, abort, k_ready,
        input  k_valid, k_data, k_round, k_last, busy, done
    );

    modport slave (
        input  start, mode, abort, k_ready,
        output k_valid, k_data, k_round, k_last, busy, done
    );
endinterface

// File: rtl/sha2_k_rom.sv
// Combinational SHA-512 round-constant lookup.
//   rnd : round index 0..79 (larger indices return 0)
//   k   : 64-bit constant K512[rnd]
module sha2_k_rom
    import sha2_pkg::*;
(
    input  logic [6:0]  rnd,
    output logic [63:0] k
);
    always_comb begin
        k = '0;
        if (rnd < 7'(SHA512_ROUNDS)) begin
            k = K512[rnd];
        end
    end
endmodule

// File: rtl/sha2_k_sequencer.sv
// SHA-2 round-constant sequencer. After a start pulse it streams K[0..63]
// (SHA-224/256, upper constant half, zero-extended) or K[0..79]
// (SHA-384/512) over a registered valid/ready interface.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/mode/abort in, k_ready in,
//                  k_valid/k_data/k_round/k_last/busy/done out
module sha2_k_sequencer
    import sha2_pkg::*;
#(
    parameter int unsigned OUT_W = 64,
    parameter int unsigned RND_W = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sha2_k_sequencer_if.slave      bus
);
    sha2_seq_state_e  state_q, state_d;
    sha2_mode_e       mode_q, mode_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             k_valid_q, k_valid_d;
    logic [OUT_W-1:0] k_data_q, k_data_d;
    logic             k_last_q, k_last_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             load;
    logic             clear;
    logic [63:0]      rom_k;
    logic [OUT_W-1:0] k_sel;

    assign xfer = k_valid_q & bus.k_ready;

    // Next round index, state and mode; the output register is loaded from
    // the ROM addressed by the *next* index, so it is the only pipeline stage.
    always_comb begin : fsm_next
        state_d = state_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            rnd_d   = '0;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        mode_d  = (OUT_W == 32) ? SHA2_MODE_256 : sha2_mode_e'(bus.mode);
                        rnd_d   = '0;
                        load    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (k_last_q) begin
                            state_d = ST_IDLE;
                            rnd_d   = '0;
                            clear   = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            rnd_d = rnd_q + RND_W'(1);
                            load  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    sha2_k_rom u_rom (
        .rnd (7'(rnd_d)),
        .k   (rom_k)
    );

    // Kept separate from fsm_next so the ROM path does not fold back into
    // the block that computes its address.
    always_comb begin : out_next
        k_valid_d = k_valid_q;
        k_data_d  = k_data_q;
        k_last_d  = k_last_q;
        if (mode_d == SHA2_MODE_512) begin
            k_sel = OUT_W'(rom_k);
        end else begin
            k_sel = OUT_W'(rom_k[63:32]);
        end
        if (clear) begin
            k_valid_d = 1'b0;
            k_data_d  = '0;
            k_last_d  = 1'b0;
        end else if (load) begin
            k_valid_d = 1'b1;
            k_data_d  = k_sel;
            k_last_d  = (rnd_d == RND_W'(sha2_last_round(mode_d)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= SHA2_MODE_256;
            rnd_q     <= '0;
            k_valid_q <= 1'b0;
            k_data_q  <= '0;
            k_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rnd_q     <= rnd_d;
            k_valid_q <= k_valid_d;
            k_data_q  <= k_data_d;
            k_last_q  <= k_last_d;
            done_q    <= done_d;
        end
    end

    assign bus.k_valid = k_valid_q;
    assign bus.k_data  = k_data_q;
    assign bus.k_round = rnd_q;
    assign bus.k_last  = k_last_q;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = done_q;
endmodule
